vmsu_nbit_pipe: RTL and testbench

// - Next-generation Vedic multiplier: WIDTH-bit operands, per-operand signed/unsigned mode, STAGES-deep pipeline.
// - Valid/ready handshake on input and output; full backpressure, no data loss.
// - Sits behind user_project_wrapper; operands are driven from la_data_in, results returned on la_data_out.

---
 rtl/vmsu_nbit_pipe.sv | 124 ++++++++++++
 tb/tb_vmsu_nbit_pipe.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vmsu_nbit_pipe.sv
// Pipelined Vedic multiplier with per-operand signed mode and valid/ready flow control.
// Optional multiply-accumulate output enabled by defining VMSU_ACC_EN.

module vmsu_vedic #(
    parameter int W = 2
) (
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] p_o
);
    generate
        if (W == 2) begin : g_base
            logic c1;
            assign c1     = a_i[1] & b_i[0] & a_i[0] & b_i[1];
            assign p_o[0] = a_i[0] & b_i[0];
            assign p_o[1] = (a_i[1] & b_i[0]) ^ (a_i[0] & b_i[1]);
            assign p_o[2] = (a_i[1] & b_i[1]) ^ c1;
            assign p_o[3] = a_i[1] & b_i[1] & c1;
        end else begin : g_rec
            localparam int H = W / 2;
            logic [W-1:0] ll, lh, hl, hh;
            vmsu_vedic #(.W(H)) u_ll (.a_i(a_i[H-1:0]), .b_i(b_i[H-1:0]), .p_o(ll));
            vmsu_vedic #(.W(H)) u_lh (.a_i(a_i[H-1:0]), .b_i(b_i[W-1:H]), .p_o(lh));
            vmsu_vedic #(.W(H)) u_hl (.a_i(a_i[W-1:H]), .b_i(b_i[H-1:0]), .p_o(hl));
            vmsu_vedic #(.W(H)) u_hh (.a_i(a_i[W-1:H]), .b_i(b_i[W-1:H]), .p_o(hh));
            // vertical (hh,ll) plus crosswise (lh,hl) terms at weight 2^H
            assign p_o = {hh, ll}
                       + {{H{1'b0}}, lh, {H{1'b0}}}
                       + {{H{1'b0}}, hl, {H{1'b0}}};
        end
    endgenerate
endmodule

module vmsu_nbit_pipe #(
    parameter int WIDTH     = 8,
    parameter int STAGES    = 3,
    parameter int ACC_GUARD = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid_i,
    output logic                         in_ready_o,
    input  logic [WIDTH-1:0]             in_a_i,
    input  logic [WIDTH-1:0]             in_b_i,
    input  logic [1:0]                   in_mode_i,
    input  logic                         in_acc_clr_i,
    output logic                         out_valid_o,
    input  logic                         out_ready_i,
    output logic [2*WIDTH-1:0]           out_p_o,
    output logic [2*WIDTH+ACC_GUARD-1:0] out_acc_o
);
    localparam int PW = 2 * WIDTH;
    localparam int AW = PW + ACC_GUARD;

    logic              advance;
    logic              a_neg, b_neg, sgn_d;
    logic [WIDTH-1:0]  a_mag, b_mag;
    logic [PW-1:0]     mag_p, p_d;

    logic [STAGES-1:0] vld_q, sgn_q, clr_q;
    logic [PW-1:0]     p_q [STAGES];

    assign advance    = ~out_valid_o | out_ready_i;
    assign in_ready_o = advance;

    // -2^(W-1) negates to itself, which reads correctly as an unsigned magnitude
    assign a_neg = in_mode_i[0] & in_a_i[WIDTH-1];
    assign b_neg = in_mode_i[1] & in_b_i[WIDTH-1];
    assign a_mag = a_neg ? -in_a_i : in_a_i;
    assign b_mag = b_neg ? -in_b_i : in_b_i;
    assign sgn_d = |in_mode_i;

    vmsu_vedic #(.W(WIDTH)) u_core (.a_i(a_mag), .b_i(b_mag), .p_o(mag_p));

    assign p_d = (a_neg ^ b_neg) ? -mag_p : mag_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            sgn_q <= '0;
            clr_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                p_q[i] <= '0;
            end
        end else if (advance) begin
            vld_q[0] <= in_valid_i;
            sgn_q[0] <= in_valid_i & sgn_d;
            clr_q[0] <= in_valid_i & in_acc_clr_i;
            p_q[0]   <= p_d;
            for (int i = 1; i < STAGES; i++) begin
                vld_q[i] <= vld_q[i-1];
                sgn_q[i] <= sgn_q[i-1];
                clr_q[i] <= clr_q[i-1];
                p_q[i]   <= p_q[i-1];
            end
        end
    end

    assign out_valid_o = vld_q[STAGES-1];
    assign out_p_o     = p_q[STAGES-1];

`ifdef VMSU_ACC_EN
    logic [AW-1:0] acc_q, acc_d, p_ext;

    assign p_ext = sgn_q[STAGES-1] ? {{ACC_GUARD{out_p_o[PW-1]}}, out_p_o}
                                   : {{ACC_GUARD{1'b0}}, out_p_o};
    // presented sum already includes the beat on the output
    assign acc_d = (clr_q[STAGES-1] ? '0 : acc_q) + p_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (out_valid_o && out_ready_i) begin
            acc_q <= acc_d;
        end
    end

    assign out_acc_o = acc_d;
`else
    logic unused_acc;
    assign unused_acc = ^{sgn_q, clr_q};
    assign out_acc_o  = {AW{1'b0}};
`endif
endmodule

// File: tb/tb_vmsu_nbit_pipe.sv
// Directed and randomized bench for vmsu_nbit_pipe; accumulator checks apply when VMSU_ACC_EN is defined.
module tb_vmsu_nbit_pipe;
    localparam int W  = 8;
    localparam int S  = 3;
    localparam int G  = 8;
    localparam int PW = 2 * W;
    localparam int AW = PW + G;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [1:0]    in_mode = '0;
    logic          in_acc_clr = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] out_p;
    logic [AW-1:0] out_acc;

    vmsu_nbit_pipe #(.WIDTH(W), .STAGES(S), .ACC_GUARD(G)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_a_i(in_a), .in_b_i(in_b), .in_mode_i(in_mode), .in_acc_clr_i(in_acc_clr),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_p_o(out_p), .out_acc_o(out_acc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] p;
        bit            sgn;
        bit            clr;
    } beat_t;

    beat_t         q[$];
    logic [AW-1:0] acc_m = '0;
    int            chk = 0;
    int            err = 0;
    bit            seen;
    logic [PW-1:0] last_p;
    logic [AW-1:0] last_acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk++;
        assert (obs === exp)
        else begin
            err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: interpret operands as integers, multiply, keep the low 2W bits
    function automatic logic [PW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] m);
        longint va = longint'(a);
        longint vb = longint'(b);
        longint pr;
        logic [63:0] t;
        if (m[0] && a[W-1]) va = va - (longint'(1) << W);
        if (m[1] && b[W-1]) vb = vb - (longint'(1) << W);
        pr = va * vb;
        t  = pr;
        return t[PW-1:0];
    endfunction

    task automatic step(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] m, input bit c, input bit r);
        logic [AW-1:0] e;
        @(negedge clk);
        in_valid = v; in_a = a; in_b = b; in_mode = m; in_acc_clr = c; out_ready = r;
        #1;
        seen     = out_valid;
        last_p   = out_p;
        last_acc = out_acc;
        check("in_ready", in_ready, (!out_valid || r));
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out", out_valid, 0);
            end else begin
                check("out_p", out_p, q[0].p);
`ifdef VMSU_ACC_EN
                e = q[0].sgn ? {{G{q[0].p[PW-1]}}, q[0].p} : {{G{1'b0}}, q[0].p};
                e = (q[0].clr ? '0 : acc_m) + e;
                check("out_acc", out_acc, e);
                if (r) acc_m = e;
`endif
                if (r) void'(q.pop_front());
            end
        end
`ifndef VMSU_ACC_EN
        e = '0;
        check("out_acc_zero", out_acc, e);
`endif
        if (v && in_ready) q.push_back('{model(a, b, m), (m != 2'b00), c});
    endtask

    task automatic single(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [1:0] m, input bit c, input logic [PW-1:0] exp_p,
                          input logic [AW-1:0] exp_acc);
        int n = 0;
        step(1, a, b, m, c, 1);
        seen = 0;
        while (!seen && n < 20) begin
            step(0, '0, '0, 2'b00, 0, 1);
            n++;
        end
        check({tag, "_latency"}, n, S);
        check({tag, "_p"}, last_p, exp_p);
`ifdef VMSU_ACC_EN
        check({tag, "_acc"}, last_acc, exp_acc);
`endif
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (q.size() != 0 && n < 40) begin
            step(0, '0, '0, 2'b00, 0, 1);
            n++;
        end
        step(0, '0, '0, 2'b00, 0, 1);
        check({tag, "_leftover"}, q.size(), 0);
        check({tag, "_idle_valid"}, out_valid, 0);
    endtask

    initial begin
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_p", out_p, 0);
        check("rst_out_acc", out_acc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, '0, '0, 2'b00, 0, 1);
        check("post_rst_in_ready", in_ready, 1);

        single("u255x255", 8'hFF, 8'hFF, 2'b00, 1, 16'hFE01, 24'h00FE01);
        single("s80x80",   8'h80, 8'h80, 2'b11, 0, 16'h4000, 24'h013E01);
        single("s80x7F",   8'h80, 8'h7F, 2'b11, 0, 16'hC080, 24'h00FE81);
        single("m01",      8'hFF, 8'hFF, 2'b01, 0, 16'hFF01, 24'h00FD82);
        single("m10",      8'hFF, 8'hFF, 2'b10, 0, 16'hFF01, 24'h00FC83);

        // Accumulator sequence: 12, 42, 28, then restart
        single("acc1", 8'd3, 8'd4, 2'b11, 1, 16'd12, 24'd12);
        single("acc2", 8'd5, 8'd6, 2'b11, 0, 16'd30, 24'd42);
        single("acc3", 8'hFE, 8'd7, 2'b11, 0, 16'hFFF2, 24'd28);
        single("acc4", 8'd2, 8'd9, 2'b11, 1, 16'd18, 24'd18);

        // Stream with a 5-cycle output stall in the middle
        for (int i = 0; i < 6; i++) step(1, W'(i * 17 + 3), W'(i * 29 + 1), 2'(i), 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, W'(i + 100), W'(i + 50), 2'b01, 0, 0);
            check("stall_in_ready", in_ready, 0);
            check("stall_out_valid", out_valid, 1);
        end
        for (int i = 0; i < 4; i++) step(1, W'(i * 7 + 9), W'(255 - i), 2'b10, 0, 1);
        drain("stall");

        // Reset with beats in flight
        for (int i = 0; i < 3; i++) step(1, W'(i + 20), W'(i + 40), 2'b00, 0, 1);
        step(0, '0, '0, 2'b00, 0, 0);
        check("inflight_valid", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("async_rst_valid", out_valid, 0);
        check("async_rst_p", out_p, 0);
        q.delete();
        acc_m = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        single("after_rst", 8'd3, 8'd5, 2'b00, 0, 16'd15, 24'd15);

        // Randomized traffic with random backpressure and bubbles
        for (int i = 0; i < 500; i++) begin
            step(($urandom % 4) != 0, W'($urandom), W'($urandom), 2'($urandom),
                 ($urandom % 6) == 0, ($urandom % 4) != 0);
        end
        drain("random");

        $display("Result: errors=%0d of %0d checks", err, chk);
        $finish;
    end
endmodule
